alu_decode: RTL and testbench
=============================

# alu_decode

Registered decode stage that turns a 32-bit RV32I instruction word into the ALU control fields (`op`, `op_imm`, `funct3`, `funct7`) plus register indices and immediate. It is the producer end of the ALU control interface: it sits between fetch and the ALU operand mux. Input and output both use a valid/ready handshake, with a 2-entry skid buffer so it sustains one instruction per cycle under backpressure.

## Interface
- `XLEN`, 32, datapath and immediate width
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: synchronous discard of all held entries
- `in_valid` in 1: instruction offered
- `in_ready` out 1: stage can accept
- `in_instr` in 32: instruction word
- `in_pc` in XLEN: instruction address
- `out_valid` out 1: decoded entry available
- `out_ready` in 1: consumer accepts
- `op` out 1: register-register ALU op (OP opcode)
- `op_imm` out 1: register-immediate ALU op (OP-IMM opcode)
- `funct3` out 3: ALU function, encoded as `f3OpInt`
- `funct7` out 7: ALU modifier; only bit 5 significant downstream
- `rs1`, `rs2`, `rd` out 5 each: register indices
- `imm` out XLEN: operand-b immediate
- `pc` out XLEN: passthrough of `in_pc`
- `illegal` out 1: instruction not executable by the ALU

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- OP (0110011):
  - `op`=1; `funct3`=instr[14:12]; `funct7`=instr[31:25]; `imm`=0.
  - Legal only if funct7=0000000, or funct7=0100000 with funct3 ∈ {ADD, SR}.
- OP-IMM (0010011):
  - `op_imm`=1; `rs2`=0.
  - funct3=SL or SR: `imm`={27'b0, instr[24:20]}; `funct7`=instr[31:25]. Legal if funct7=0000000, or funct7=0100000 with SR.
  - All other funct3: `imm`=sign-extended instr[31:20]; `funct7` is forced to 0. This keeps a negative ADDI from selecting subtract.
- Any other opcode, or an illegal combination:
  - `illegal`=1 and `op`=`op_imm`=0.
  - Index and pc fields still pass through.
  - The entry is still delivered, never dropped.
- Field extraction is combinational into the entry register. No decoding happens on the output side.

## Timing
- Latency: an accepted instruction appears with `out_valid`=1 on the cycle after acceptance.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Skid buffer:
  - Output register plus one skid register.
  - `in_ready` = !skid_valid && !rst.
  - When the output is stalled, an accepted entry goes to skid.
  - When the output drains, skid moves to the output on the same edge.
- Ordering: strictly FIFO. No loss and no duplication.
- Simultaneous transfers: an in and an out transfer in the same cycle with the skid empty keep occupancy constant.
- Holding rule: while `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- Reset:
  - Both valid bits clear.
  - `out_valid`=0 and `in_ready`=0 during `rst`.
  - `in_ready`=1 on the first cycle after `rst` deasserts.
  - Data outputs reset to 0 and `illegal`=0.
- Flush: clears both valid bits at the edge. An input transfer in the flush cycle is discarded. Flush concurrent with `rst` behaves as reset.

## Structure
- Shared package (`def.sv`) holds:
  - the opcode constants `OPC_OP`=7'b0110011 and `OPC_OP_IMM`=7'b0010011;
  - the existing `f3OpInt` enum;
  - a packed struct `alu_dec_t` with fields op, op_imm, funct3, funct7, rs1, rs2, rd, imm, pc, illegal.
- One sub-module, `skid_buf`, parameterised on payload width and carrying the `alu_dec_t` entries. The decode logic is a combinational block in `alu_decode`.

## Test plan
- ADD x3,x1,x2 (0x002081B3) → next cycle:
  - op=1, op_imm=0;
  - funct3=0, funct7=0;
  - rs1=1, rs2=2, rd=3;
  - imm=0, illegal=0.
- ADDI x5,x0,-100 (0xF9C00293) → op_imm=1, funct3=0, funct7=0 (not 0x7C), imm=0xFFFFFF9C, rd=5.
- SRAI x1,x1,4 (0x4040D093) → op_imm=1, funct3=5, funct7=0x20, imm=4, illegal=0.
- MUL x0,x1,x2 (0x02208033) → illegal=1, op=0, op_imm=0; the entry is still delivered.
- Streaming with backpressure:
  - Stream 4 back-to-back instructions with `out_ready`=0 for 2 cycles.
  - `in_ready` drops after the 2nd acceptance.
  - All 4 emerge in order with no duplicates.
- Flush and reset:
  - Assert `flush` with both entries full → `out_valid`=0 on the next cycle.
  - Assert `rst` mid-stream → `out_valid`=0 and `in_ready`=0 during reset; `in_ready`=1 on the cycle after release.

Source files
------------

// File: rtl/alu_decode_pkg.sv
// Shared decode definitions: opcodes, ALU function encoding and the decoded entry.
package alu_decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct7 values the ALU understands; only bit 5 matters downstream
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SL   = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SR   = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } f3OpInt;

    typedef struct packed {
        logic            op;
        logic            op_imm;
        f3OpInt          funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } alu_dec_t;

    localparam int ALU_DEC_W = $bits(alu_dec_t);

endpackage

// File: rtl/alu_decode_if.sv
// Fetch-side and ALU-side handshake bundle of the decode stage.
interface alu_decode_if;
    import alu_decode_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic            op;
    logic            op_imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;

    // Environment view: offers instructions, consumes decoded entries
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, op, op_imm, funct3, funct7,
               rs1, rs2, rd, imm, pc, illegal
    );

    // Decode stage view
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, op, op_imm, funct3, funct7,
               rs1, rs2, rd, imm, pc, illegal
    );

endinterface

// File: rtl/alu_decode_skid_buf.sv
// Two-entry skid buffer: an output register plus one skid register, strict FIFO order.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         skid_valid_q;
    logic [W-1:0] skid_data_q;
    logic         in_fire;
    logic         out_free;

    // Input is refused only when the skid slot is occupied or the block is in reset
    assign in_ready  = !skid_valid_q && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_free  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Output/skid register update; skid drains into the output before new input is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values;
            // data registers are reset too so the outputs read as zero out of reset.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is full, so no input competes here
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_data_q  <= in_data;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the new entry, leave the output untouched
            skid_data_q  <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_decode.sv
// RV32I decode stage producing ALU control fields behind a skid-buffered handshake.
module alu_decode
    import alu_decode_pkg::*;
(
    input logic        clk,
    input logic        rst,
    alu_decode_if.slave bus
);

    alu_dec_t   dec;
    alu_dec_t   q;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [ALU_DEC_W-1:0] sb_out_data;

    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];

    // Field extraction and legality check, registered by the skid buffer
    always_comb begin
        // NOTE: default every field first so no path leaves a field unassigned (no latch).
        dec        = '0;
        dec.rs1    = bus.in_instr[19:15];
        dec.rs2    = bus.in_instr[24:20];
        dec.rd     = bus.in_instr[11:7];
        dec.pc     = bus.in_pc;
        dec.funct3 = f3OpInt'(f3);
        case (opcode)
            OPC_OP: begin
                dec.funct7 = f7;
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
                    dec.op = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.rs2 = '0;
                if (f3 == F3_SL || f3 == F3_SR) begin
                    dec.imm    = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                    dec.funct7 = f7;
                    if (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SR)) begin
                        dec.op_imm = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    // funct7 stays zero so a negative immediate never selects subtract
                    dec.imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                    dec.op_imm = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    skid_buf #(.W(ALU_DEC_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (sb_out_data)
    );

    assign q           = alu_dec_t'(sb_out_data);
    assign bus.op      = q.op;
    assign bus.op_imm  = q.op_imm;
    assign bus.funct3  = q.funct3;
    assign bus.funct7  = q.funct7;
    assign bus.rs1     = q.rs1;
    assign bus.rs2     = q.rs2;
    assign bus.rd      = q.rd;
    assign bus.imm     = q.imm;
    assign bus.pc      = q.pc;
    assign bus.illegal = q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Directed bench for alu_decode: field decode, illegal cases, backpressure, flush, reset.
module tb_alu_decode;
    import alu_decode_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_decode_if bus ();

    alu_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic alu_dec_t observe();
        alu_dec_t o;
        o.op      = bus.op;
        o.op_imm  = bus.op_imm;
        o.funct3  = f3OpInt'(bus.funct3);
        o.funct7  = bus.funct7;
        o.rs1     = bus.rs1;
        o.rs2     = bus.rs2;
        o.rd      = bus.rd;
        o.imm     = bus.imm;
        o.pc      = bus.pc;
        o.illegal = bus.illegal;
        return o;
    endfunction

    // Offer one instruction with the consumer ready; leaves it on the output
    task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        alu_dec_t o;
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_instr = '0; bus.in_pc = '0;
        step();
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset.valid_ready got=%b%b want=00", bus.out_valid, bus.in_ready);
        end
        o = observe();
        total++;
        if (o !== alu_dec_t'('0)) begin
            bad++;
            $display("FAIL reset.data got=%h want=0", o);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset.in_ready_after got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        alu_dec_t e;
        alu_dec_t o;
        send_one(32'h002081B3, 32'h0000_1000);
        e = '{op:1'b1, op_imm:1'b0, funct3:F3_ADD, funct7:7'h00, rs1:5'd1, rs2:5'd2,
              rd:5'd3, imm:32'h0, pc:32'h0000_1000, illegal:1'b0};
        o = observe();
        total++;
        if (bus.out_valid !== 1'b1 || o !== e) begin
            bad++;
            $display("FAIL add v=%b got=%h want=%h", bus.out_valid, o, e);
        end
        step();
    endtask

    task automatic test_addi_neg();
        alu_dec_t e;
        alu_dec_t o;
        send_one(32'hF9C00293, 32'h0000_1004);
        e = '{op:1'b0, op_imm:1'b1, funct3:F3_ADD, funct7:7'h00, rs1:5'd0, rs2:5'd0,
              rd:5'd5, imm:32'hFFFF_FF9C, pc:32'h0000_1004, illegal:1'b0};
        o = observe();
        total++;
        if (bus.out_valid !== 1'b1 || o !== e) begin
            bad++;
            $display("FAIL addi v=%b got=%h want=%h", bus.out_valid, o, e);
        end
        step();
    endtask

    task automatic test_srai();
        alu_dec_t e;
        alu_dec_t o;
        send_one(32'h4040D093, 32'h0000_1008);
        e = '{op:1'b0, op_imm:1'b1, funct3:F3_SR, funct7:7'h20, rs1:5'd1, rs2:5'd0,
              rd:5'd1, imm:32'h4, pc:32'h0000_1008, illegal:1'b0};
        o = observe();
        total++;
        if (bus.out_valid !== 1'b1 || o !== e) begin
            bad++;
            $display("FAIL srai v=%b got=%h want=%h", bus.out_valid, o, e);
        end
        step();
    endtask

    task automatic test_illegal();
        // MUL x0,x1,x2: funct7=0000001 is not an ALU op, still delivered
        send_one(32'h02208033, 32'h0000_100C);
        total++;
        if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.op !== 1'b0 ||
            bus.op_imm !== 1'b0 || bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2 || bus.rd !== 5'd0 ||
            bus.pc !== 32'h0000_100C) begin
            bad++;
            $display("FAIL mul v=%b ill=%b op=%b opi=%b rs=%0d/%0d/%0d pc=%h want 1 1 0 0 1/2/0 100c",
                     bus.out_valid, bus.illegal, bus.op, bus.op_imm, bus.rs1, bus.rs2, bus.rd, bus.pc);
        end
        step();
        // SLL with funct7=0100000 is not a legal OP combination
        send_one(32'h40209233, 32'h0000_1010);
        total++;
        if (bus.illegal !== 1'b1 || bus.op !== 1'b0 || bus.rd !== 5'd4) begin
            bad++;
            $display("FAIL sll_alt ill=%b op=%b rd=%0d want 1 0 4", bus.illegal, bus.op, bus.rd);
        end
        step();
        // SLLI with funct7=0100000 is illegal on the immediate side as well
        send_one(32'h40209213, 32'h0000_1014);
        total++;
        if (bus.illegal !== 1'b1 || bus.op_imm !== 1'b0) begin
            bad++;
            $display("FAIL slli_alt ill=%b opi=%b want 1 0", bus.illegal, bus.op_imm);
        end
        step();
        // LUI is not an ALU opcode
        send_one(32'h000010B7, 32'h0000_1018);
        total++;
        if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.op !== 1'b0 ||
            bus.op_imm !== 1'b0 || bus.rd !== 5'd1) begin
            bad++;
            $display("FAIL lui v=%b ill=%b op=%b opi=%b rd=%0d want 1 1 0 0 1",
                     bus.out_valid, bus.illegal, bus.op, bus.op_imm, bus.rd);
        end
        step();
    endtask

    task automatic test_back_to_back();
        // ADDI xN,x0,N for N=1..4
        logic [31:0] instr_q [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        int sent = 0;
        int recv = 0;
        logic in_fire, out_fire;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            bus.in_valid  = (sent < 4);
            bus.in_instr  = (sent < 4) ? instr_q[sent] : 32'h0;
            bus.in_pc     = 32'h2000 + 32'(sent * 4);
            bus.out_ready = (cyc >= 2);
            if (cyc == 1 || cyc == 2) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.rd !== 5'd1) begin
                    bad++;
                    $display("FAIL b2b.hold cyc=%0d v=%b rd=%0d want 1 1", cyc, bus.out_valid, bus.rd);
                end
            end
            if (cyc == 2) begin
                total++;
                if (bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b.in_ready_drop got=%b want=0", bus.in_ready);
                end
            end
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                total++;
                if (bus.rd !== 5'(recv + 1) || bus.imm !== 32'(recv + 1) ||
                    bus.pc !== 32'h2000 + 32'(recv * 4)) begin
                    bad++;
                    $display("FAIL b2b.order idx=%0d rd=%0d imm=%0h pc=%h want rd=%0d",
                             recv, bus.rd, bus.imm, bus.pc, recv + 1);
                end
                recv++;
            end
            if (in_fire) sent++;
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if (recv != 4) begin
            bad++;
            $display("FAIL b2b.count got=%0d want=4", recv);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b.no_dup out_valid=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00100093;
        step();
        bus.in_instr  = 32'h00200113;
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush.full v=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        // Skid full so in_ready is low; flush must still empty both slots
        bus.flush    = 1'b1;
        bus.in_instr = 32'h00300193;
        step();
        bus.flush = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush.clear v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        // Input transfer coinciding with flush is discarded
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush.discard v=%b want 0", bus.out_valid);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush.stay_empty v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send_one(32'h00500293, 32'h0000_3000);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid.in_ready_comb got=%b want=0", bus.in_ready);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.imm !== 32'h0 ||
            bus.rd !== 5'd0 || bus.illegal !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid.during v=%b rdy=%b imm=%h rd=%0d ill=%b want 0 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.imm, bus.rd, bus.illegal);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid.release rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_neg();
        test_srai();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
